logic_gate_pipe: RTL

- Parametrised, pipelined successor to the team's 2-input gate primitives.
- Applies one of eight bitwise two-operand functions to WIDTH-bit operands and returns a registered result with zero/all-ones flags.
- Uses a valid/ready stream interface with full backpressure, and keeps a saturating count of delivered results.
- Sits between an operand producer and a result consumer in the datapath test fixtures and small ALU experiments.

---
 rtl/logic_gate_pkg.sv | 23 ++
 rtl/logic_gate_fn.sv | 46 ++++
 rtl/logic_gate_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// -----------------------------------------------------------------------------
// logic_gate_pkg
// Shared definitions for the pipelined bitwise gate block and its function
// sub-module.
//   OP_W  : width of the function-select code.
//   op_t  : the eight bitwise two-operand functions, OP_AND .. OP_PASSA.
// -----------------------------------------------------------------------------
package logic_gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,   // a & ~b
        OP_PASSA = 3'd7    // y = a
    } op_t;

endpackage : logic_gate_pkg

// File: rtl/logic_gate_fn.sv
// -----------------------------------------------------------------------------
// logic_gate_fn
// Purely combinational bitwise two-operand function unit.
//   a  [WIDTH]  operand A
//   b  [WIDTH]  operand B
//   op [OP_W]   function select (logic_gate_pkg::op_t encoding)
//   y  [WIDTH]  result
// Each op is reduced to a 4-entry truth table indexed by {a_bit, b_bit};
// every result bit is then a single lookup into that table.
// -----------------------------------------------------------------------------
module logic_gate_fn
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    // tt[{a,b}] : bit 3 = (1,1), bit 2 = (1,0), bit 1 = (0,1), bit 0 = (0,0)
    logic [3:0] tt;

    always_comb begin
        tt = 4'b0000;
        case (op_t'(op))
            OP_AND:   tt = 4'b1000;
            OP_OR:    tt = 4'b1110;
            OP_XOR:   tt = 4'b0110;
            OP_NAND:  tt = 4'b0111;
            OP_NOR:   tt = 4'b0001;
            OP_XNOR:  tt = 4'b1001;
            OP_ANDN:  tt = 4'b0100;
            OP_PASSA: tt = 4'b1100;
            default:  tt = 4'b0000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = tt[{a[gi], b[gi]}];
        end
    endgenerate

endmodule : logic_gate_fn

// File: rtl/logic_gate_pipe.sv
// -----------------------------------------------------------------------------
// logic_gate_pipe
// Two-stage valid/ready pipeline applying a bitwise function to two operands.
// S1 registers the operand beat, S2 registers the function result and flags.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid          in_ready   block accepts beat
//   a, b       operands [WIDTH]            op         function select [3]
//   out_valid  result beat valid           out_ready  consumer accepts result
//   o          result [WIDTH]              o_zero     o == 0
//   o_ones     o == all ones               o_op       op that produced o
//   res_count  saturating count of delivered results [CNT_W]
// -----------------------------------------------------------------------------
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_zero,
    output logic             o_ones,
    output logic [OP_W-1:0]  o_op,
    output logic [CNT_W-1:0] res_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1: captured operands
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [OP_W-1:0]  s1_op_q;

    // Stage 2: registered result
    logic             s2_valid_q;
    logic [WIDTH-1:0] o_q;
    logic             o_zero_q;
    logic             o_ones_q;
    logic [OP_W-1:0]  o_op_q;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             out_fire;
    logic [WIDTH-1:0] fn_y;

    // An empty stage always advances, so bubbles collapse even when stalled.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_fire = s2_valid_q && out_ready;

    logic_gate_fn #(
        .WIDTH (WIDTH)
    ) u_fn (
        .a  (s1_a_q),
        .b  (s1_b_q),
        .op (s1_op_q),
        .y  (fn_y)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (out_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            o_q        <= '0;
            o_zero_q   <= 1'b1;
            o_ones_q   <= 1'b0;
            o_op_q     <= '0;
            cnt_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                // Operands are only sampled on a real beat, so undriven
                // operands while idle never reach the result path.
                if (in_valid) begin
                    s1_a_q  <= a;
                    s1_b_q  <= b;
                    s1_op_q <= op;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    o_q      <= fn_y;
                    o_zero_q <= ~|fn_y;
                    o_ones_q <= &fn_y;
                    o_op_q   <= s1_op_q;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign o         = o_q;
    assign o_zero    = o_zero_q;
    assign o_ones    = o_ones_q;
    assign o_op      = o_op_q;
    assign res_count = cnt_q;

endmodule : logic_gate_pipe
